pipelined_subtractor_32bit: RTL and testbench

- Streaming 32-bit unsigned subtractor: diff = a - b, computed in 8-bit slices across a 4-stage pipeline with a ripple borrow between stages.
- It is the subtract-direction counterpart of the sliced adder tree.
- Valid/ready on both sides with full backpressure; sustains one result per cycle when the sink is ready.
- Sits in the datapath wherever operands arrive as a stream and results may stall.

---
 rtl/pipelined_subtractor_32bit.sv | 86 ++++++++
 tb/tb_pipelined_subtractor_32bit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_subtractor_32bit.sv
// pipelined_subtractor_32bit: streaming unsigned a - b, one SLICE-bit slice per stage with a
// registered borrow rippling between stages and a combinational valid/ready chain.
module pipelined_subtractor_32bit #(
    parameter int WIDTH  = 32,
    parameter int SLICE  = 8,
    parameter int STAGES = WIDTH / SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);
    logic [STAGES-1:0] v, adv, load, bo_r, bi;
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH-1:0]  d_r [STAGES];
    logic [WIDTH-1:0]  sa [STAGES];
    logic [WIDTH-1:0]  sb [STAGES];
    logic [WIDTH-1:0]  sd [STAGES];
    logic [WIDTH-1:0]  dn [STAGES];
    logic [SLICE:0]    s [STAGES];
    logic              z_r;
    assign in_ready  = !v[0] || adv[0];
    assign out_valid = v[STAGES-1];
    assign diff      = d_r[STAGES-1];
    assign borrow    = bo_r[STAGES-1];
    assign zero      = z_r;
    // Ready chain resolved from the output end so each stage sees its successor's decision.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = v[STAGES-1] && out_ready;
        for (int k = STAGES - 2; k >= 0; k--)
            adv[k] = v[k] && (!v[k+1] || adv[k+1]);
        load = {adv[STAGES-2:0], in_valid && in_ready};
    end
    // Operands shift down one slice per stage, so the active slice is always the low SLICE bits;
    // the partial diff shifts in from the top and is fully aligned after the last stage.
    always_comb begin
        sa[0] = a;
        sb[0] = b;
        sd[0] = '0;
        bi    = '0;
        for (int k = 1; k < STAGES; k++) begin
            sa[k] = a_r[k-1];
            sb[k] = b_r[k-1];
            sd[k] = d_r[k-1];
            bi[k] = bo_r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            s[k]  = {1'b0, sa[k][SLICE-1:0]} - {1'b0, sb[k][SLICE-1:0]} - {{SLICE{1'b0}}, bi[k]};
            dn[k] = {s[k][SLICE-1:0], sd[k][WIDTH-1:SLICE]};
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v    <= '0;
            bo_r <= '0;
            z_r  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                d_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k] || adv[k])
                    v[k] <= load[k];
                if (load[k]) begin
                    a_r[k]  <= sa[k] >> SLICE;
                    b_r[k]  <= sb[k] >> SLICE;
                    d_r[k]  <= dn[k];
                    bo_r[k] <= s[k][SLICE];
                end
            end
            if (load[STAGES-1])
                z_r <= dn[STAGES-1] == '0;
        end
    end
endmodule

// File: tb/tb_pipelined_subtractor_32bit.sv
// tb_pipelined_subtractor_32bit: directed and scoreboarded checks of the streaming subtractor.
module tb_pipelined_subtractor_32bit;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, borrow, zero;
    logic [31:0] a = '0, b = '0, diff;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    pipelined_subtractor_32bit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow), .zero(zero)
    );

    // Inputs change just after the falling edge; outputs are read 1ns later, well before the next rise.
    task automatic drive(input logic iv, input logic [31:0] ia, input logic [31:0] ib, input logic ordy);
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; out_ready = ordy;
        #1;
    endtask

    task automatic run_one(input logic [31:0] ia, input logic [31:0] ib,
                           output logic [31:0] d, output logic bo, output logic z, output int lat);
        drive(1'b1, ia, ib, 1'b1);
        lat = 0;
        do begin
            drive(1'b0, 32'h0, 32'h0, 1'b1);
            lat++;
        end while (out_valid !== 1'b1 && lat < 20);
        d = diff; bo = borrow; z = zero;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_held_out_valid got %b want 0", out_valid); else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (diff !== 32'h0) $display("FAIL reset_diff got %h want 0", diff); else passed++;
        total++; if (borrow !== 1'b0) $display("FAIL reset_borrow got %b want 0", borrow); else passed++;
        total++; if (zero !== 1'b0) $display("FAIL reset_zero got %b want 0", zero); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_single;
        logic [31:0] d; logic bo, z; int lat;
        run_one(32'h1234_5678, 32'h0234_5677, d, bo, z, lat);
        total++; if (lat != 4) $display("FAIL single_latency got %0d want 4", lat); else passed++;
        total++; if (d !== 32'h1000_0001) $display("FAIL single_diff got %h want 10000001", d); else passed++;
        total++; if (bo !== 1'b0) $display("FAIL single_borrow got %b want 0", bo); else passed++;
        total++; if (z !== 1'b0) $display("FAIL single_zero got %b want 0", z); else passed++;
    endtask

    task automatic test_borrow;
        logic [31:0] d; logic bo, z; int lat;
        run_one(32'h0000_0000, 32'h0000_0001, d, bo, z, lat);
        total++; if (d !== 32'hFFFF_FFFF) $display("FAIL wrap_diff got %h want ffffffff", d); else passed++;
        total++; if (bo !== 1'b1) $display("FAIL wrap_borrow got %b want 1", bo); else passed++;
        total++; if (z !== 1'b0) $display("FAIL wrap_zero got %b want 0", z); else passed++;
        run_one(32'hDEAD_BEEF, 32'hDEAD_BEEF, d, bo, z, lat);
        total++; if (d !== 32'h0) $display("FAIL equal_diff got %h want 0", d); else passed++;
        total++; if (bo !== 1'b0) $display("FAIL equal_borrow got %b want 0", bo); else passed++;
        total++; if (z !== 1'b1) $display("FAIL equal_zero got %b want 1", z); else passed++;
        run_one(32'h8000_0000, 32'h0000_0001, d, bo, z, lat);
        total++; if (d !== 32'h7FFF_FFFF) $display("FAIL ripple_diff got %h want 7fffffff", d); else passed++;
        total++; if (bo !== 1'b0) $display("FAIL ripple_borrow got %b want 0", bo); else passed++;
        run_one(32'h0000_0100, 32'h0000_0001, d, bo, z, lat);
        total++; if (d !== 32'h0000_00FF) $display("FAIL slice_ripple_diff got %h want 000000ff", d); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] xa [16];
        logic [31:0] xb [16];
        logic [31:0] e;
        int got = 0;
        bit ready_ok = 1'b1, timing_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            xa[i] = $urandom; xb[i] = $urandom;
        end
        for (int c = 0; c < 24; c++) begin
            drive(c < 16, c < 16 ? xa[c] : 32'h0, c < 16 ? xb[c] : 32'h0, 1'b1);
            if (c < 16 && in_ready !== 1'b1) ready_ok = 1'b0;
            if (out_valid === 1'b1) begin
                if (c != got + 4) timing_ok = 1'b0;
                e = got < 16 ? xa[got] - xb[got] : 32'h0;
                total++; if (got >= 16 || diff !== e) $display("FAIL b2b_diff[%0d] got %h want %h", got, diff, e); else passed++;
                got++;
            end
        end
        total++; if (!ready_ok) $display("FAIL b2b_in_ready got low want always high"); else passed++;
        total++; if (!timing_ok) $display("FAIL b2b_timing got gaps want one result per cycle from cycle 4"); else passed++;
        total++; if (got != 16) $display("FAIL b2b_count got %0d want 16", got); else passed++;
    endtask

    task automatic test_backpressure;
        logic [31:0] pa [4] = '{32'h0000_0010, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        logic [31:0] pb [4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0005, 32'hFFFF_FFFF};
        logic [31:0] ex [4] = '{32'h0000_000F, 32'h7FFF_FFFF, 32'hFFFF_FFFB, 32'h0000_0000};
        logic [3:0]  eb = 4'b0100, ez = 4'b1000;
        logic [31:0] held = '0;
        int acc = 0, got = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, acc < 4 ? pa[acc] : 32'h1, acc < 4 ? pb[acc] : 32'h1, 1'b0);
            if (in_ready === 1'b1) acc++;
            if (c == 5) held = diff;
        end
        total++; if (acc != 4) $display("FAIL bp_accepted got %0d want 4", acc); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got %b want 1", out_valid); else passed++;
        total++; if (diff !== held || held !== ex[0]) $display("FAIL bp_stable got %h then %h want %h", held, diff, ex[0]); else passed++;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1);
            if (out_valid === 1'b1) begin
                if (got < 4) begin
                    total++;
                    if (diff !== ex[got] || borrow !== eb[got] || zero !== ez[got])
                        $display("FAIL bp_drain[%0d] got %h/%b/%b want %h/%b/%b", got, diff, borrow, zero, ex[got], eb[got], ez[got]);
                    else passed++;
                end
                got++;
            end
        end
        total++; if (got != 4) $display("FAIL bp_drain_count got %0d want 4", got); else passed++;
    endtask

    task automatic test_random;
        logic [33:0] q [$];
        logic [33:0] e;
        logic [31:0] ra = '0, rb = '0, sdiff = '0;
        logic pend = 1'b0, stall = 1'b0, ordy;
        int sent = 0, recv = 0, cyc = 0;
        while (recv < 1000 && cyc < 20000) begin
            if (!pend && sent < 1000 && $urandom_range(0, 1) == 1) begin
                pend = 1'b1; ra = $urandom; rb = $urandom;
                if ($urandom_range(0, 15) == 0) rb = ra;
            end
            ordy = 1'($urandom_range(0, 1));
            drive(pend, ra, rb, ordy);
            cyc++;
            if (stall) begin
                total++;
                if (out_valid !== 1'b1 || diff !== sdiff) $display("FAIL rand_stable got %b/%h want 1/%h", out_valid, diff, sdiff);
                else passed++;
            end
            if (pend && in_ready === 1'b1) begin
                q.push_back({ra < rb, ra == rb, ra - rb});
                sent++; pend = 1'b0;
            end
            if (out_valid === 1'b1 && ordy) begin
                total++;
                if (q.size() == 0) $display("FAIL rand_spurious got %h want no output", diff);
                else begin
                    e = q.pop_front();
                    if ({borrow, zero, diff} !== e) $display("FAIL rand_result[%0d] got %h want %h", recv, {borrow, zero, diff}, e);
                    else passed++;
                end
                recv++;
            end
            stall = out_valid === 1'b1 && !ordy;
            sdiff = diff;
        end
        total++; if (recv != 1000) $display("FAIL rand_count got %0d want 1000", recv); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic bo, z; int lat, extra = 0;
        drive(1'b1, 32'd100, 32'd1, 1'b0);
        drive(1'b1, 32'd200, 32'd2, 1'b0);
        drive(1'b1, 32'd300, 32'd3, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", out_valid); else passed++;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_async_drop got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", in_ready); else passed++;
        @(negedge clk);
        rst = 1'b0;
        run_one(32'd5, 32'd3, d, bo, z, lat);
        total++; if (lat != 4) $display("FAIL mid_latency got %0d want 4", lat); else passed++;
        total++; if (d !== 32'd2 || bo !== 1'b0 || z !== 1'b0) $display("FAIL mid_result got %h/%b/%b want 2/0/0", d, bo, z); else passed++;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1);
            if (out_valid !== 1'b0) extra++;
        end
        total++; if (extra != 0) $display("FAIL mid_leftover got %0d want 0", extra); else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_borrow;
        test_back_to_back;
        test_backpressure;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
